// File: rtl/lift_call_scheduler.sv
// SCAN scheduler for a single lift car: latches floor calls, steps the car floor by floor,
// and sequences the door through opening/hold/closing. All outputs decode from registered state.
module lift_call_scheduler #(
    parameter int NUM_FLOORS       = 11,
    parameter int FLOOR_W          = 4,
    parameter int MOVE_CYCLES      = 4,
    parameter int DOOR_MOVE_CYCLES = 2,
    parameter int DOOR_HOLD_CYCLES = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  door_obstacle,
    input  logic                  door_open_btn,
    input  logic                  door_close_btn,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  up_dir,
    output logic                  down_dir,
    output logic                  door_opening,
    output logic                  door_closing,
    output logic                  door_is_open,
    output logic                  ready
);
    localparam int MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DCW = (DOOR_MOVE_CYCLES > 1) ? $clog2(DOOR_MOVE_CYCLES) : 1;
    localparam int HCW = (DOOR_HOLD_CYCLES > 1) ? $clog2(DOOR_HOLD_CYCLES) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MOVING  = 3'd1;
    localparam logic [2:0] S_OPENING = 3'd2;
    localparam logic [2:0] S_OPEN    = 3'd3;
    localparam logic [2:0] S_CLOSING = 3'd4;

    logic [2:0]            state;
    logic                  dir;        // 1 = up
    logic [MCW-1:0]        move_cnt;
    logic [DCW-1:0]        door_cnt;
    logic [HCW-1:0]        hold_cnt;
    logic [NUM_FLOORS-1:0] here_mask, below_mask, above_mask, clr;
    logic                  above, below, next_hit, next_is_end, enter_open, here_call, door_hold;

    always_comb begin
        here_mask   = NUM_FLOORS'(1) << cur_floor;
        below_mask  = here_mask - NUM_FLOORS'(1);
        above_mask  = ~(below_mask | here_mask);
        above       = |(pending & above_mask);
        below       = |(pending & below_mask);
        next_hit    = dir ? |(pending & (here_mask << 1)) : |(pending & (here_mask >> 1));
        // Safety stop if the floor being entered is a shaft end with nothing pending there.
        next_is_end = dir ? (cur_floor == FLOOR_W'(NUM_FLOORS-2)) : (cur_floor == FLOOR_W'(1));
        enter_open  = (state == S_OPENING) && (door_cnt == '0);
        here_call   = |(call_req & here_mask);
        door_hold   = door_obstacle || door_open_btn;
        clr         = ((state == S_OPEN) || enter_open) ? here_mask : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            dir       <= 1'b1;
            cur_floor <= '0;
            pending   <= '0;
            move_cnt  <= '0;
            door_cnt  <= '0;
            hold_cnt  <= '0;
        end else begin
            pending <= (pending | call_req) & ~clr;
            case (state)
                S_IDLE: begin
                    if (|(pending & here_mask) || door_open_btn) begin
                        state    <= S_OPENING;
                        door_cnt <= DCW'(DOOR_MOVE_CYCLES-1);
                    end else if (dir ? above : below) begin
                        state    <= S_MOVING;
                        move_cnt <= MCW'(MOVE_CYCLES-1);
                    end else if (dir ? below : above) begin
                        dir      <= ~dir;
                        state    <= S_MOVING;
                        move_cnt <= MCW'(MOVE_CYCLES-1);
                    end
                end
                S_MOVING: begin
                    if (move_cnt == '0) begin
                        cur_floor <= dir ? cur_floor + 1'b1 : cur_floor - 1'b1;
                        if (next_hit) begin
                            state    <= S_OPENING;
                            door_cnt <= DCW'(DOOR_MOVE_CYCLES-1);
                        end else if (next_is_end) begin
                            state <= S_IDLE;
                        end else begin
                            move_cnt <= MCW'(MOVE_CYCLES-1);
                        end
                    end else begin
                        move_cnt <= move_cnt - 1'b1;
                    end
                end
                S_OPENING: begin
                    if (door_cnt == '0) begin
                        state    <= S_OPEN;
                        hold_cnt <= HCW'(DOOR_HOLD_CYCLES-1);
                    end else begin
                        door_cnt <= door_cnt - 1'b1;
                    end
                end
                S_OPEN: begin
                    if (door_hold || here_call) begin
                        hold_cnt <= HCW'(DOOR_HOLD_CYCLES-1);
                    end else if (door_close_btn || hold_cnt == '0) begin
                        state    <= S_CLOSING;
                        door_cnt <= DCW'(DOOR_MOVE_CYCLES-1);
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                S_CLOSING: begin
                    if (door_hold) begin
                        state    <= S_OPENING;
                        door_cnt <= DCW'(DOOR_MOVE_CYCLES-1);
                    end else if (door_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        door_cnt <= door_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign up_dir       = (state == S_MOVING) && dir;
    assign down_dir     = (state == S_MOVING) && !dir;
    assign door_opening = (state == S_OPENING);
    assign door_is_open = (state == S_OPEN);
    assign door_closing = (state == S_CLOSING);
    assign ready        = (state == S_IDLE);

    floor_in_range: assert property (@(posedge clk) disable iff (rst)
        {1'b0, cur_floor} < (FLOOR_W+1)'(NUM_FLOORS));
endmodule
